// File: rtl/link_bringup_ctrl.sv
// Transceiver link bring-up: CDR acquisition dwell, bit-slip search for the
// training word, confirmation run, then pass-through of user payload.
module link_bringup_ctrl #(
    parameter int unsigned LOCK_CYCLES = 256,
    parameter int unsigned MATCH_COUNT = 16,
    parameter logic [9:0]  TRAIN_WORD  = 10'h0FA
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       retrain,
    input  logic [3:0] tx_swing_cfg,
    input  logic [9:0] data_tx_in,
    output logic [9:0] data_tx_out,
    input  logic [9:0] data_rx_in,
    output logic [9:0] data_rx_out,
    output logic       rx_valid,
    output logic [3:0] tx_swing,
    output logic       cdr_mode,
    output logic       aligned,
    output logic [2:0] state,
    output logic [3:0] slip,
    output logic [7:0] sweep_fail_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CDR_ACQ = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_CONFIRM = 3'd3,
        ST_LINKED  = 3'd4
    } state_t;

    localparam logic [15:0] LOCK_LAST   = 16'(LOCK_CYCLES - 1);
    localparam logic [7:0]  MATCH_LIMIT = 8'(MATCH_COUNT);

    state_t      state_r;
    logic [15:0] lock_cnt_r;
    logic [7:0]  match_cnt_r;
    logic [3:0]  slip_r;
    logic        blank_r;
    logic [7:0]  fail_cnt_r;
    logic [9:0]  rx_prev_r;
    logic [9:0]  rx_word_r;
    logic [19:0] window_s;
    logic [9:0]  slip_word_s;
    logic        match_s;

    function automatic logic [3:0] slip_advance(input logic [3:0] s);
        return (s == 4'd9) ? 4'd0 : s + 4'd1;
    endfunction

    function automatic logic [7:0] fail_bump(input logic [7:0] c);
        return (c == 8'd255) ? c : c + 8'd1;
    endfunction

    assign window_s = {data_rx_in, rx_prev_r};
    assign match_s  = (rx_word_r == TRAIN_WORD);

    // Select the 10-bit field of the two-word window at the current slip offset
    always_comb begin
        slip_word_s = 10'(window_s >> slip_r);
    end

    // Receive alignment pipeline
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_prev_r <= 10'h000;
            rx_word_r <= 10'h000;
        end else begin
            rx_prev_r <= data_rx_in;
            rx_word_r <= slip_word_s;
        end
    end

    // Bring-up state machine; enable drop outranks retrain, retrain outranks data
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            lock_cnt_r  <= 16'd0;
            match_cnt_r <= 8'd0;
            slip_r      <= 4'd0;
            blank_r     <= 1'b0;
            fail_cnt_r  <= 8'd0;
        end else if (!enable) begin
            state_r    <= ST_IDLE;
            lock_cnt_r <= 16'd0;
        end else if (retrain && (state_r == ST_SEARCH || state_r == ST_CONFIRM ||
                                 state_r == ST_LINKED)) begin
            state_r    <= ST_CDR_ACQ;
            lock_cnt_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_CDR_ACQ;
                    lock_cnt_r <= 16'd0;
                end
                ST_CDR_ACQ: begin
                    if (lock_cnt_r == LOCK_LAST) begin
                        state_r     <= ST_SEARCH;
                        slip_r      <= 4'd0;
                        blank_r     <= 1'b1;
                        match_cnt_r <= 8'd0;
                    end else begin
                        lock_cnt_r <= lock_cnt_r + 16'd1;
                    end
                end
                ST_SEARCH: begin
                    // rx_word still reflects the old offset on the blank cycle
                    if (blank_r) begin
                        blank_r <= 1'b0;
                    end else if (match_s) begin
                        match_cnt_r <= 8'd1;
                        state_r     <= (MATCH_LIMIT == 8'd1) ? ST_LINKED : ST_CONFIRM;
                    end else begin
                        slip_r  <= slip_advance(slip_r);
                        blank_r <= 1'b1;
                        if (slip_r == 4'd9) begin
                            fail_cnt_r <= fail_bump(fail_cnt_r);
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (match_s) begin
                        match_cnt_r <= match_cnt_r + 8'd1;
                        if (match_cnt_r + 8'd1 == MATCH_LIMIT) begin
                            state_r <= ST_LINKED;
                        end
                    end else begin
                        state_r     <= ST_SEARCH;
                        match_cnt_r <= 8'd0;
                        slip_r      <= slip_advance(slip_r);
                        blank_r     <= 1'b1;
                        if (slip_r == 4'd9) begin
                            fail_cnt_r <= fail_bump(fail_cnt_r);
                        end
                    end
                end
                ST_LINKED: begin
                    state_r <= ST_LINKED;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the state register
    always_comb begin
        data_tx_out = 10'h000;
        tx_swing    = tx_swing_cfg;
        cdr_mode    = 1'b0;
        aligned     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                data_tx_out = 10'h000;
                tx_swing    = 4'h0;
            end
            ST_CDR_ACQ: begin
                data_tx_out = TRAIN_WORD;
                cdr_mode    = 1'b1;
            end
            ST_SEARCH, ST_CONFIRM: begin
                data_tx_out = TRAIN_WORD;
            end
            ST_LINKED: begin
                data_tx_out = data_tx_in;
                aligned     = 1'b1;
            end
            default: begin
                data_tx_out = 10'h000;
                tx_swing    = 4'h0;
            end
        endcase
    end

    assign rx_valid       = aligned;
    assign data_rx_out    = rx_word_r;
    assign state          = state_r;
    assign slip           = slip_r;
    assign sweep_fail_cnt = fail_cnt_r;

endmodule

// File: tb/tb_link_bringup_ctrl.sv
// Randomized bench for link_bringup_ctrl: a behavioural model of the bring-up
// rules predicts every output each cycle; directed phases hit the corner cases.
module tb_link_bringup_ctrl;

    localparam int LOCK   = 8;
    localparam int MATCHN = 4;
    localparam logic [9:0] TW = 10'h0FA;
    localparam int M_IDLE = 0, M_CDR = 1, M_SEARCH = 2, M_CONFIRM = 3, M_LINKED = 4;

    logic       clock;
    logic       reset, enable, retrain;
    logic [3:0] tx_swing_cfg;
    logic [9:0] data_tx_in, data_rx_in;
    logic [9:0] data_tx_out, data_rx_out;
    logic       rx_valid, cdr_mode, aligned;
    logic [3:0] tx_swing, slip;
    logic [2:0] state;
    logic [7:0] sweep_fail_cnt;

    link_bringup_ctrl #(.LOCK_CYCLES(LOCK), .MATCH_COUNT(MATCHN), .TRAIN_WORD(TW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .retrain(retrain),
        .tx_swing_cfg(tx_swing_cfg), .data_tx_in(data_tx_in), .data_tx_out(data_tx_out),
        .data_rx_in(data_rx_in), .data_rx_out(data_rx_out), .rx_valid(rx_valid),
        .tx_swing(tx_swing), .cdr_mode(cdr_mode), .aligned(aligned), .state(state),
        .slip(slip), .sweep_fail_cnt(sweep_fail_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // model of the link controller
    int m_state = 0, m_slip = 0, m_lock = 0, m_match = 0, m_fail = 0;
    bit m_blank = 0;
    logic [9:0] m_prev = 10'h000, m_word = 10'h000;

    // stimulus control and history
    int  rx_mode = 0;     // 0 random, 1 loopback+3, 2 silent, 3 planted training word
    int  fake_slip = 2;
    bit  rand_ctrl = 0;
    int  loop_cnt = 0;
    int  cdr_seen = 0;
    int  aligned_seen = 0;
    logic [9:0] tx1 = 10'h000, tx2 = 10'h000;
    logic [9:0] dtx_q[$];
    int         st_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] exp_tx(input logic [9:0] dtx);
        if (m_state == M_LINKED) return dtx;
        if (m_state == M_IDLE) return 10'h000;
        return TW;
    endfunction

    // word R for which any window {R,R} read at offset k gives TW
    function automatic logic [9:0] rot_for(input int k);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[(i + k) % 10] = TW[i];
        return r;
    endfunction

    task automatic miss_advance();
        m_slip  = (m_slip + 1) % 10;
        m_blank = 1;
        if (m_slip == 0 && m_fail < 255) m_fail = m_fail + 1;
    endtask

    task automatic model_update();
        logic [19:0] win;
        logic [9:0]  nw;
        bit          hit;
        win = {data_rx_in, m_prev};
        for (int i = 0; i < 10; i++) nw[i] = win[m_slip + i];
        hit = (m_word == TW);
        if (reset) begin
            m_state = M_IDLE; m_slip = 0; m_lock = 0; m_match = 0; m_fail = 0; m_blank = 0;
            nw = 10'h000; data_rx_hold_clear();
        end else if (!enable) begin
            m_state = M_IDLE; m_lock = 0;
        end else if (retrain && m_state >= M_SEARCH) begin
            m_state = M_CDR; m_lock = 0;
        end else if (m_state == M_IDLE) begin
            m_state = M_CDR; m_lock = 0;
        end else if (m_state == M_CDR) begin
            m_lock = m_lock + 1;
            if (m_lock == LOCK) begin
                m_state = M_SEARCH; m_slip = 0; m_blank = 1; m_match = 0;
            end
        end else if (m_state == M_SEARCH) begin
            if (m_blank) m_blank = 0;
            else if (hit) begin
                m_match = 1;
                m_state = (m_match >= MATCHN) ? M_LINKED : M_CONFIRM;
            end else miss_advance();
        end else if (m_state == M_CONFIRM) begin
            if (hit) begin
                m_match = m_match + 1;
                if (m_match == MATCHN) m_state = M_LINKED;
            end else begin
                m_match = 0; m_state = M_SEARCH; miss_advance();
            end
        end
        m_word = nw;
        m_prev = reset ? 10'h000 : data_rx_in;
    endtask

    task automatic data_rx_hold_clear();
        m_prev = 10'h000;
    endtask

    task automatic check_all();
        chk("state", {29'd0, state}, m_state);
        chk("slip", {28'd0, slip}, m_slip);
        chk("sweep_fail_cnt", {24'd0, sweep_fail_cnt}, m_fail);
        chk("data_rx_out", {22'd0, data_rx_out}, {22'd0, m_word});
        chk("data_tx_out", {22'd0, data_tx_out}, {22'd0, exp_tx(data_tx_in)});
        chk("cdr_mode", {31'd0, cdr_mode}, (m_state == M_CDR) ? 1 : 0);
        chk("tx_swing", {28'd0, tx_swing}, (m_state == M_IDLE) ? 0 : {28'd0, tx_swing_cfg});
        chk("aligned", {31'd0, aligned}, (m_state == M_LINKED) ? 1 : 0);
        chk("rx_valid", {31'd0, rx_valid}, (m_state == M_LINKED) ? 1 : 0);
        if (loop_cnt >= 3 && st_q.size() >= 3 && st_q[0] == M_LINKED &&
            st_q[1] == M_LINKED && st_q[2] == M_LINKED && m_slip == 3)
            chk("loop_latency", {22'd0, data_rx_out}, {22'd0, dtx_q[2]});
        if (cdr_mode === 1'b1) cdr_seen++;
        if (aligned === 1'b1) aligned_seen++;
    endtask

    task automatic set_inputs();
        logic [9:0] tx_now;
        data_tx_in = 10'($urandom);
        if (rand_ctrl) begin
            enable  = ($urandom_range(0, 59) != 0);
            retrain = ($urandom_range(0, 49) == 0);
            reset   = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 19) == 0) tx_swing_cfg = 4'($urandom);
        end else begin
            retrain = 1'b0;
        end
        tx_now = exp_tx(data_tx_in);
        case (rx_mode)
            1: begin data_rx_in = {tx1[6:0], tx2[9:7]}; loop_cnt++; end
            2: begin data_rx_in = 10'h000; loop_cnt = 0; end
            3: begin
                loop_cnt = 0;
                if (m_state == M_SEARCH && ((m_slip == fake_slip - 1 && !m_blank) ||
                                            (m_slip == fake_slip && m_blank)))
                    data_rx_in = rot_for(fake_slip);
                else if (m_state == M_SEARCH && m_slip == fake_slip && !m_blank)
                    data_rx_in = 10'h3FF;
                else
                    data_rx_in = 10'h000;
            end
            default: begin data_rx_in = 10'($urandom); loop_cnt = 0; end
        endcase
        tx2 = tx1;
        tx1 = tx_now;
        dtx_q.push_front(data_tx_in);
        st_q.push_front(m_state);
        if (dtx_q.size() > 4) void'(dtx_q.pop_back());
        if (st_q.size() > 4) void'(st_q.pop_back());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            model_update();
            @(negedge clock);
            check_all();
            set_inputs();
        end
    endtask

    task automatic wait_state(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (state !== 3'(target) && k < budget) begin
            run(1);
            k++;
        end
        chk(tag, {29'd0, state}, target);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; retrain = 1'b0;
        tx_swing_cfg = 4'h5; data_tx_in = 10'h000; data_rx_in = 10'h000;

        // reset state
        run(3);
        chk("rst_data_tx_out", {22'd0, data_tx_out}, 32'd0);
        chk("rst_tx_swing", {28'd0, tx_swing}, 32'd0);
        chk("rst_state", {29'd0, state}, 32'd0);

        // nominal loopback bring-up with a 3-bit window offset
        reset = 1'b0; enable = 1'b1; rx_mode = 1; cdr_seen = 0; aligned_seen = 0;
        run(80);
        chk("nom_cdr_len", cdr_seen, LOCK);
        chk("nom_slip", {28'd0, slip}, 32'd3);
        chk("nom_aligned", {31'd0, aligned}, 32'd1);
        chk("nom_sweep", {24'd0, sweep_fail_cnt}, 32'd0);

        // retrain from LINKED
        retrain = 1'b1;
        run(1);
        chk("rt_state", {29'd0, state}, M_CDR);
        chk("rt_cdr_mode", {31'd0, cdr_mode}, 32'd1);
        chk("rt_tx", {22'd0, data_tx_out}, {22'd0, TW});
        run(60);
        chk("rt_relinked", {31'd0, aligned}, 32'd1);

        // enable drop together with retrain
        enable = 1'b0; retrain = 1'b1;
        run(1);
        chk("off_state", {29'd0, state}, M_IDLE);
        chk("off_swing", {28'd0, tx_swing}, 32'd0);

        // no signal: three full sweeps in 60 cycles
        pulse_reset();
        enable = 1'b1; rx_mode = 2;
        wait_state(M_SEARCH, 40, "nosig_enter");
        aligned_seen = 0;
        run(60);
        chk("nosig_sweep", {24'd0, sweep_fail_cnt}, 32'd3);
        chk("nosig_slip", {28'd0, slip}, 32'd0);
        chk("nosig_aligned", aligned_seen, 32'd0);

        // single false training word at slip 2
        pulse_reset();
        enable = 1'b1; rx_mode = 3; fake_slip = 2;
        wait_state(M_CONFIRM, 60, "fm_confirm");
        chk("fm_confirm_slip", {28'd0, slip}, 32'd2);
        run(1);
        chk("fm_back_state", {29'd0, state}, M_SEARCH);
        chk("fm_back_slip", {28'd0, slip}, 32'd3);

        // reset while in CONFIRM at slip 7
        pulse_reset();
        enable = 1'b1; fake_slip = 7;
        wait_state(M_CONFIRM, 80, "rc_confirm");
        chk("rc_slip7", {28'd0, slip}, 32'd7);
        reset = 1'b1;
        run(1);
        chk("rc_state", {29'd0, state}, 32'd0);
        chk("rc_slip", {28'd0, slip}, 32'd0);
        chk("rc_tx", {22'd0, data_tx_out}, 32'd0);
        chk("rc_cdr", {31'd0, cdr_mode}, 32'd0);
        chk("rc_valid", {31'd0, rx_valid}, 32'd0);
        reset = 1'b0;

        // sweep counter saturation
        pulse_reset();
        enable = 1'b1; rx_mode = 2;
        run(20 * 260 + 40);
        chk("sat_sweep", {24'd0, sweep_fail_cnt}, 32'd255);

        // randomized control and data mix
        rand_ctrl = 1'b1;
        for (int p = 0; p < 20; p++) begin
            rx_mode = ($urandom_range(0, 2) == 0) ? 0 : 1;
            run(100);
        end
        rand_ctrl = 1'b0; reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
